// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and defaults for the pipeline hazard controller
// Contents: ctrl_state_t FSM encoding, default TIMEOUT and counter width.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } ctrl_state_t;

    localparam int DEF_TIMEOUT = 64;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
// master: pipeline side (drives decode/EXE/MEM status, clr_cnt; reads controls and counters)
// slave : controller side (reads status; drives hazard, mem_freeze, flush, mem_timeout, counters)
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();

    logic [3:0]       src1;
    logic [3:0]       src2;
    logic             Two_src;
    logic [3:0]       EXE_Dest;
    logic             EXE_MEM_R_EN;
    logic             EXE_WB_EN;
    logic             mem_req;
    logic             mem_ready;
    logic             branch_taken;
    logic             clr_cnt;
    logic             hazard;
    logic             mem_freeze;
    logic             flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output src1, src2, Two_src, EXE_Dest, EXE_MEM_R_EN, EXE_WB_EN,
               mem_req, mem_ready, branch_taken, clr_cnt,
        input  hazard, mem_freeze, flush, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  src1, src2, Two_src, EXE_Dest, EXE_MEM_R_EN, EXE_WB_EN,
               mem_req, mem_ready, branch_taken, clr_cnt,
        output hazard, mem_freeze, flush, mem_timeout, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// rtl/pipe_hazard_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
// Ports: clk, rst (async, active-high), clr (priority clear), inc (count enable), q (count).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use hazard, memory freeze, branch flush and timeout sequencer
// Ports: clk, rst (async, active-high), bus (slave side of pipe_hazard_ctrl_if).
// hazard/mem_freeze/flush are combinational; mem_timeout and counters are registered.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    ctrl_state_t       state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic              freeze;
    logic              load_use;
    logic              flush;
    logic              hazard;

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        mem_timeout_d = mem_timeout_q;
        freeze        = 1'b0;
        case (state_q)
            RUN: begin
                freeze = bus.mem_req & ~bus.mem_ready;
                if (freeze) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = '0;
                end
            end
            MEM_WAIT: begin
                freeze = ~bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = RUN;
                end else if (wcnt_q == WCNT_LAST) begin
                    state_d       = HALT;
                    mem_timeout_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            HALT: begin
                freeze = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            wcnt_q        <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign load_use = bus.EXE_MEM_R_EN & bus.EXE_WB_EN &
                      ((bus.EXE_Dest == bus.src1) |
                       (bus.Two_src & (bus.EXE_Dest == bus.src2)));

    // A frozen branch keeps branch_taken asserted, so its flush simply
    // happens on the first unfrozen cycle.
    assign flush  = bus.branch_taken & ~freeze;
    // The decode instruction is discarded by a flush, so no bubble is needed.
    assign hazard = load_use & ~freeze & ~flush;

    assign bus.hazard      = hazard;
    assign bus.mem_freeze  = freeze;
    assign bus.flush       = flush;
    assign bus.mem_timeout = mem_timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clr_cnt),
        .inc (hazard | freeze),
        .q   (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clr_cnt),
        .inc (flush),
        .q   (bus.flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    pipe_hazard_ctrl_if #(.CNT_W(4)) bus ();

    pipe_hazard_ctrl #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.src1 = 4'd0; bus.src2 = 4'd0; bus.Two_src = 1'b0; bus.EXE_Dest = 4'd0;
        bus.EXE_MEM_R_EN = 1'b0; bus.EXE_WB_EN = 1'b0; bus.mem_req = 1'b0;
        bus.mem_ready = 1'b0; bus.branch_taken = 1'b0; bus.clr_cnt = 1'b0;
    endtask

    task automatic clear_counters();
        bus.clr_cnt = 1'b1;
        step();
        bus.clr_cnt = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        idle_inputs();
        #1;
        check("rst_timeout", 32'(bus.mem_timeout), 32'd0);
        check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        check("rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
        check("rst_outputs", {29'd0, bus.hazard, bus.mem_freeze, bus.flush}, 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(RUN));
        step();
        step();
        rst = 1'b0;

        // Load-use on src1, then src2 with and without Two_src
        bus.EXE_MEM_R_EN = 1'b1; bus.EXE_WB_EN = 1'b1; bus.EXE_Dest = 4'd3; bus.src1 = 4'd3;
        #1 check("lu_src1_hazard", 32'(bus.hazard), 32'd1);
        step();
        check("lu_src1_stall_cnt", 32'(bus.stall_cnt), 32'd1);
        bus.src1 = 4'd5; bus.src2 = 4'd3; bus.Two_src = 1'b0;
        #1 check("lu_src2_no_two_src", 32'(bus.hazard), 32'd0);
        step();
        check("lu_no_hazard_cnt", 32'(bus.stall_cnt), 32'd1);
        bus.Two_src = 1'b1;
        #1 check("lu_src2_two_src", 32'(bus.hazard), 32'd1);
        bus.EXE_WB_EN = 1'b0;
        #1 check("lu_no_wb", 32'(bus.hazard), 32'd0);
        idle_inputs();
        clear_counters();
        check("clr_stall_cnt", 32'(bus.stall_cnt), 32'd0);

        // Cache miss: 4 not-ready cycles then ready
        bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("miss_freeze_%0d", i), 32'(bus.mem_freeze), 32'd1);
            step();
        end
        bus.mem_ready = 1'b1;
        #1 check("miss_release_freeze", 32'(bus.mem_freeze), 32'd0);
        step();
        check("miss_state_run", 32'(dut.state_q), 32'(RUN));
        check("miss_stall_cnt", 32'(bus.stall_cnt), 32'd4);
        // Single-cycle hit: ready together with request in RUN
        #1 check("hit_no_freeze", 32'(bus.mem_freeze), 32'd0);
        step();
        check("hit_state_run", 32'(dut.state_q), 32'(RUN));
        check("hit_stall_cnt", 32'(bus.stall_cnt), 32'd4);
        idle_inputs();
        clear_counters();

        // Branch held during a 3-cycle freeze
        bus.mem_req = 1'b1; bus.mem_ready = 1'b0; bus.branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("br_frozen_flush_%0d", i), 32'(bus.flush), 32'd0);
            step();
        end
        bus.mem_ready = 1'b1;
        #1 check("br_release_flush", 32'(bus.flush), 32'd1);
        step();
        check("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);
        check("br_stall_cnt", 32'(bus.stall_cnt), 32'd3);
        idle_inputs();
        clear_counters();

        // Flush takes priority over load-use
        bus.EXE_MEM_R_EN = 1'b1; bus.EXE_WB_EN = 1'b1; bus.EXE_Dest = 4'd7;
        bus.src1 = 4'd7; bus.branch_taken = 1'b1;
        #1 check("fvh_flush", 32'(bus.flush), 32'd1);
        check("fvh_hazard", 32'(bus.hazard), 32'd0);
        step();
        check("fvh_flush_cnt", 32'(bus.flush_cnt), 32'd1);
        check("fvh_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        bus.branch_taken = 1'b0;

        // Saturation: 20 hazard cycles on a 4-bit counter
        for (int i = 0; i < 20; i++) step();
        check("sat_stall_cnt", 32'(bus.stall_cnt), 32'd15);
        bus.clr_cnt = 1'b1;
        step();
        check("sat_clr_priority", 32'(bus.stall_cnt), 32'd0);
        bus.clr_cnt = 1'b0;
        step();
        check("sat_recount", 32'(bus.stall_cnt), 32'd1);
        idle_inputs();
        clear_counters();

        // Timeout: miss detected in RUN, then TIMEOUT MEM_WAIT cycles
        bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        #1 check("to_run_freeze", 32'(bus.mem_freeze), 32'd1);
        step();
        for (int i = 0; i < 8; i++) begin
            if (bus.mem_timeout !== 1'b0)
                check($sformatf("to_early_%0d", i), 32'(bus.mem_timeout), 32'd0);
            step();
        end
        check("to_timeout_set", 32'(bus.mem_timeout), 32'd1);
        check("to_state_halt", 32'(dut.state_q), 32'(HALT));
        step();
        check("to_sticky", 32'(bus.mem_timeout), 32'd1);
        check("to_halt_freeze", 32'(bus.mem_freeze), 32'd1);
        #2 rst = 1'b1;
        #1 check("arst_timeout", 32'(bus.mem_timeout), 32'd0);
        check("arst_state", 32'(dut.state_q), 32'(RUN));
        check("arst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        rst = 1'b0;
        bus.mem_req = 1'b0;
        #1 check("arst_freeze_idle", 32'(bus.mem_freeze), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
